fir_filter_param: RTL and testbench

Parameterised, time-multiplexed FIR filter. It is the successor to the fixed 4-tap filter: tap count, data/coefficient widths and sample-count period are configurable, with optional magnitude output and signed saturation. It uses one multiply-accumulate per clock under a control FSM. It sits between the sample source (data_ready handshake) and the output consumer (out_valid strobe).

---
 rtl/fir_filter_param.sv | 212 +++++++++++++++++++++
 tb/tb_fir_filter_param.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_filter_param.sv
`default_nettype none
// ============================================================================
//  Module   : fir_filter_param
//  Purpose  : Time-multiplexed FIR filter with one multiply-accumulate per
//             clock. Tap count, data/coefficient widths, output-count period
//             and magnitude output are parameters. The result is rescaled
//             from Q1.(COEF_W-1), optionally rectified, and saturated to
//             DATA_W bits.
//  Ports    : clk             rising-edge clock
//             rst             synchronous active-high reset
//             sample_data     signed input sample (DATA_W)
//             data_ready      sample strobe, accepted only in IDLE
//             fir_coefficient signed coefficient (COEF_W)
//             load_coeff      coefficient write strobe, accepted only in IDLE
//             fir_out         registered filter result (DATA_W)
//             out_valid       one-cycle pulse when fir_out updates
//             modwait         busy, high whenever the FSM is not IDLE
//             count_done      pulses with every SAMPLE_CNT-th out_valid
//             err             sticky error: dropped request or saturation
//  Revision : 1.0 - initial release
// ============================================================================
module fir_filter_param #(
    parameter int NTAPS      = 4,
    parameter int DATA_W     = 16,
    parameter int COEF_W     = 16,
    parameter int SAMPLE_CNT = 1000,
    parameter int MAG_OUT    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              data_ready,
    input  logic [COEF_W-1:0] fir_coefficient,
    input  logic              load_coeff,
    output logic [DATA_W-1:0] fir_out,
    output logic              out_valid,
    output logic              modwait,
    output logic              count_done,
    output logic              err
);

    localparam int c_prod_w = DATA_W + COEF_W;
    localparam int c_ext_w  = $clog2(NTAPS);
    localparam int c_acc_w  = c_prod_w + c_ext_w;
    localparam int c_idx_w  = $clog2(NTAPS);
    localparam int c_cnt_w  = $clog2(SAMPLE_CNT + 1);

    // Output range expressed at accumulator width so the comparisons are
    // made on the full-precision shifted result.
    localparam logic signed [c_acc_w-1:0] c_sat_max =
        {{(c_acc_w-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [c_acc_w-1:0] c_sat_min =
        {{(c_acc_w-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_MAC   = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t                      r_state;
    state_t                      w_next;
    logic signed [DATA_W-1:0]    r_x    [NTAPS];
    logic signed [COEF_W-1:0]    r_coef [NTAPS];
    logic        [c_idx_w-1:0]   r_ptr;
    logic        [c_idx_w-1:0]   r_idx;
    logic signed [c_acc_w-1:0]   r_acc;
    logic signed [DATA_W-1:0]    r_sample;
    logic        [c_cnt_w-1:0]   r_cnt;
    logic        [DATA_W-1:0]    r_fir_out;
    logic                        r_out_valid;
    logic                        r_count_done;
    logic                        r_err;

    logic                        w_accept;
    logic                        w_load;
    logic                        w_busy_req;
    logic                        w_last_tap;
    logic signed [COEF_W-1:0]    w_coef_sel;
    logic signed [DATA_W-1:0]    w_x_sel;
    logic signed [c_prod_w-1:0]  w_coef_ext;
    logic signed [c_prod_w-1:0]  w_x_ext;
    logic signed [c_prod_w-1:0]  w_prod;
    logic signed [c_acc_w-1:0]   w_prod_ext;
    logic signed [c_acc_w-1:0]   w_shifted;
    logic signed [c_acc_w-1:0]   w_mag;
    logic                        w_sat;
    logic        [DATA_W-1:0]    w_y;

    assign w_accept   = (r_state == S_IDLE) && data_ready;
    assign w_load     = (r_state == S_IDLE) && load_coeff;
    assign w_busy_req = (r_state != S_IDLE) && (data_ready || load_coeff);
    assign w_last_tap = (r_idx == c_idx_w'(NTAPS - 1));

    // Operands are sign-extended to the product width so the multiply is a
    // plain same-width operation; the full signed product fits exactly.
    assign w_coef_sel = r_coef[r_idx];
    assign w_x_sel    = r_x[r_idx];
    assign w_coef_ext = {{DATA_W{w_coef_sel[COEF_W-1]}}, w_coef_sel};
    assign w_x_ext    = {{COEF_W{w_x_sel[DATA_W-1]}}, w_x_sel};
    assign w_prod     = w_coef_ext * w_x_ext;
    assign w_prod_ext = {{c_ext_w{w_prod[c_prod_w-1]}}, w_prod};

    // Rescale from Q1.(COEF_W-1) with floor rounding, optional rectify,
    // then clamp to the signed DATA_W range.
    always_comb begin
        w_shifted = r_acc >>> (COEF_W - 1);
        w_mag     = w_shifted;
        if ((MAG_OUT != 0) && w_shifted[c_acc_w-1]) begin
            w_mag = -w_shifted;
        end
        w_sat = 1'b0;
        w_y   = w_mag[DATA_W-1:0];
        if (w_mag > c_sat_max) begin
            w_sat = 1'b1;
            w_y   = c_sat_max[DATA_W-1:0];
        end else if (w_mag < c_sat_min) begin
            w_sat = 1'b1;
            w_y   = c_sat_min[DATA_W-1:0];
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (data_ready) w_next = S_SHIFT;
            S_SHIFT: w_next = S_MAC;
            S_MAC:   if (w_last_tap) w_next = S_OUT;
            S_OUT:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            for (int i = 0; i < NTAPS; i++) begin
                r_x[i]    <= '0;
                r_coef[i] <= '0;
            end
            r_ptr        <= '0;
            r_idx        <= '0;
            r_acc        <= '0;
            r_sample     <= '0;
            r_cnt        <= '0;
            r_fir_out    <= '0;
            r_out_valid  <= 1'b0;
            r_count_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_out_valid  <= 1'b0;
            r_count_done <= 1'b0;

            if (w_load) begin
                r_coef[r_ptr] <= fir_coefficient;
                r_ptr         <= w_ptr_next(r_ptr);
            end

            if (w_accept) begin
                r_sample <= sample_data;
            end

            case (r_state)
                S_SHIFT: begin
                    for (int i = NTAPS - 1; i > 0; i--) begin
                        r_x[i] <= r_x[i-1];
                    end
                    r_x[0] <= r_sample;
                    r_acc  <= '0;
                    r_idx  <= '0;
                end
                S_MAC: begin
                    r_acc <= r_acc + w_prod_ext;
                    r_idx <= w_last_tap ? '0 : r_idx + c_idx_w'(1);
                end
                S_OUT: begin
                    r_fir_out   <= w_y;
                    r_out_valid <= 1'b1;
                    if (r_cnt == c_cnt_w'(SAMPLE_CNT - 1)) begin
                        r_cnt        <= '0;
                        r_count_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                default: ;
            endcase

            // Setting wins over clearing; the two cannot coincide anyway
            // because acceptance only happens in IDLE.
            if (w_busy_req || ((r_state == S_OUT) && w_sat)) begin
                r_err <= 1'b1;
            end else if (w_accept) begin
                r_err <= 1'b0;
            end
        end
    end

    function automatic logic [c_idx_w-1:0] w_ptr_next(input logic [c_idx_w-1:0] p);
        return (p == c_idx_w'(NTAPS - 1)) ? '0 : p + c_idx_w'(1);
    endfunction

    assign fir_out    = r_fir_out;
    assign out_valid  = r_out_valid;
    assign modwait    = (r_state != S_IDLE);
    assign count_done = r_count_done;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fir_filter_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_filter_param
//  Purpose  : Self-checking bench for fir_filter_param. Instance 0 is the
//             plain filter with an 8-output count period; instance 1 has
//             magnitude output enabled. Expected results are queued when a
//             sample is driven and compared when out_valid appears.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fir_filter_param;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0][15:0] sd;
    logic [1:0][15:0] cf;
    logic [1:0]       dr;
    logic [1:0]       lc;

    logic [15:0] fo0, fo1;
    logic        ov0, ov1, mw0, mw1, cd0, cd1, er0, er1;
    logic [1:0]  ov_v, mw_v, er_v;

    assign ov_v = {ov1, ov0};
    assign mw_v = {mw1, mw0};
    assign er_v = {er1, er0};

    always #5 clk = ~clk;

    fir_filter_param #(
        .NTAPS(4), .DATA_W(16), .COEF_W(16), .SAMPLE_CNT(8), .MAG_OUT(0)
    ) dut0 (
        .clk(clk), .rst(rst),
        .sample_data(sd[0]), .data_ready(dr[0]),
        .fir_coefficient(cf[0]), .load_coeff(lc[0]),
        .fir_out(fo0), .out_valid(ov0), .modwait(mw0),
        .count_done(cd0), .err(er0)
    );

    fir_filter_param #(
        .NTAPS(4), .DATA_W(16), .COEF_W(16), .SAMPLE_CNT(1000), .MAG_OUT(1)
    ) dut1 (
        .clk(clk), .rst(rst),
        .sample_data(sd[1]), .data_ready(dr[1]),
        .fir_coefficient(cf[1]), .load_coeff(lc[1]),
        .fir_out(fo1), .out_valid(ov1), .modwait(mw1),
        .count_done(cd1), .err(er1)
    );

    typedef struct {
        logic [15:0] y;
        logic        e;
        logic        cd;
    } exp_t;

    typedef struct {
        int          sel;
        bit          rl;      // reset and load coefficients first
        logic [63:0] c;       // {c3,c2,c1,c0}
        logic [15:0] s;
        logic [15:0] y;
        bit          e;
        bit          cc;      // check that acceptance clears err
    } vec_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t m0, m1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Output monitor / scoreboard
    always @(negedge clk) begin
        if (ov0) begin
            if (q0.size() == 0) begin
                chk("unexpected_out_valid0", 32'(ov0), 0);
            end else begin
                m0 = q0.pop_front();
                chk("fir_out0", 32'(fo0), 32'(m0.y));
                chk("err0", 32'(er0), 32'(m0.e));
                chk("count_done0", 32'(cd0), 32'(m0.cd));
            end
        end else if (cd0) begin
            chk("count_done0_without_out_valid", 32'(cd0), 0);
        end
        if (ov1) begin
            if (q1.size() == 0) begin
                chk("unexpected_out_valid1", 32'(ov1), 0);
            end else begin
                m1 = q1.pop_front();
                chk("fir_out1", 32'(fo1), 32'(m1.y));
                chk("err1", 32'(er1), 32'(m1.e));
                chk("count_done1", 32'(cd1), 32'(m1.cd));
            end
        end
    end

    task automatic push(input int sel, input logic [15:0] y, input bit e, input bit cdx);
        exp_t t;
        t.y = y; t.e = e; t.cd = cdx;
        if (sel == 0) q0.push_back(t);
        else          q1.push_back(t);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_fir_out0"}, 32'(fo0), 0);
        chk({tag, "_ov0"},      32'(ov0), 0);
        chk({tag, "_modwait0"}, 32'(mw0), 0);
        chk({tag, "_cd0"},      32'(cd0), 0);
        chk({tag, "_err0"},     32'(er0), 0);
        chk({tag, "_fir_out1"}, 32'(fo1), 0);
        chk({tag, "_err1"},     32'(er1), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; dr = '0; lc = '0; cf = '0; sd = '0;
        @(negedge clk);
        rst = 1'b0;
        chk_zero_outputs("reset");
    endtask

    task automatic load(input int sel, input logic [63:0] c);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            lc[sel] = 1'b1;
            cf[sel] = c[16*i +: 16];
        end
        @(negedge clk);
        lc[sel] = 1'b0;
    endtask

    task automatic wait_ov(input int sel);
        int cyc;
        cyc = 0;
        while (!ov_v[sel] && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("out_valid_seen", 32'(ov_v[sel]), 1);
    endtask

    task automatic send(input int sel, input logic [15:0] s, input logic [15:0] y,
                        input bit e, input bit cdx, input bit chk_clr);
        int cyc;
        int mwc;
        push(sel, y, e, cdx);
        @(negedge clk);
        sd[sel] = s;
        dr[sel] = 1'b1;
        @(negedge clk);
        dr[sel] = 1'b0;
        if (chk_clr) chk("err_cleared_on_accept", 32'(er_v[sel]), 0);
        cyc = 0;
        mwc = 0;
        while (!ov_v[sel] && cyc < 40) begin
            if (mw_v[sel]) mwc++;
            @(negedge clk);
            cyc++;
        end
        chk("out_latency", 32'(cyc), 6);
        chk("modwait_cycles", 32'(mwc), 6);
        chk("modwait_low_at_out", 32'(mw_v[sel]), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[14];
        tbl[0]  = '{0, 1, 64'h0000_0000_4000_4000, 16'd100,  16'd150 - 16'd100, 0, 0};
        tbl[1]  = '{0, 0, 64'h0,                   16'd200,  16'd150,  0, 0};
        tbl[2]  = '{0, 1, 64'h7FFF_7FFF_7FFF_7FFF, 16'h7FFF, 16'd32766, 0, 0};
        tbl[3]  = '{0, 0, 64'h0,                   16'h7FFF, 16'h7FFF, 1, 0};
        tbl[4]  = '{0, 0, 64'h0,                   16'h0000, 16'h7FFF, 1, 1};
        tbl[5]  = '{0, 1, 64'h0000_0000_C000_4000, 16'hFFFD, 16'hFFFE, 0, 0};
        tbl[6]  = '{0, 0, 64'h0,                   16'h0007, 16'h0005, 0, 0};
        tbl[7]  = '{0, 0, 64'h0,                   16'hFF9C, 16'hFFCA, 0, 0};
        tbl[8]  = '{0, 1, 64'h7FFF_7FFF_7FFF_7FFF, 16'h8000, 16'h8001, 0, 0};
        tbl[9]  = '{0, 0, 64'h0,                   16'h8000, 16'h8000, 1, 0};
        tbl[10] = '{1, 1, 64'h0000_0000_0000_8000, 16'd100,  16'd100,  0, 0};
        tbl[11] = '{1, 0, 64'h0,                   16'h8000, 16'h7FFF, 1, 0};
        tbl[12] = '{1, 1, 64'h0000_0000_0000_4000, 16'hFF9C, 16'd50,   0, 0};
        tbl[13] = '{1, 0, 64'h0,                   16'hFFFD, 16'd2,    0, 0};

        rst = 1'b1; dr = '0; lc = '0; cf = '0; sd = '0;
        do_reset();

        for (int i = 0; i < 14; i++) begin
            if (tbl[i].rl) begin
                do_reset();
                load(tbl[i].sel, tbl[i].c);
            end
            send(tbl[i].sel, tbl[i].s, tbl[i].y, tbl[i].e, 1'b0, tbl[i].cc);
        end

        // Coefficient write coinciding with sample acceptance is used at once.
        do_reset();
        push(0, 16'd50, 1'b0, 1'b0);
        @(negedge clk);
        lc[0] = 1'b1; cf[0] = 16'h4000; dr[0] = 1'b1; sd[0] = 16'd100;
        @(negedge clk);
        lc[0] = 1'b0; dr[0] = 1'b0;
        wait_ov(0);

        // Sample arriving while busy is dropped and flags err.
        do_reset();
        load(0, 64'h0000_0000_4000_4000);
        push(0, 16'd50, 1'b1, 1'b0);
        @(negedge clk); sd[0] = 16'd100; dr[0] = 1'b1;
        @(negedge clk); dr[0] = 1'b0;
        @(negedge clk); sd[0] = 16'd999; dr[0] = 1'b1;
        @(negedge clk); dr[0] = 1'b0;
        chk("err_on_dropped_sample", 32'(er0), 1);
        wait_ov(0);
        repeat (10) @(negedge clk);
        send(0, 16'd200, 16'd150, 1'b0, 1'b0, 1'b0);

        // Coefficient write while busy is ignored.
        do_reset();
        load(0, 64'h0000_0000_4000_4000);
        push(0, 16'd50, 1'b1, 1'b0);
        @(negedge clk); sd[0] = 16'd100; dr[0] = 1'b1;
        @(negedge clk); dr[0] = 1'b0;
        @(negedge clk); lc[0] = 1'b1; cf[0] = 16'h7FFF;
        @(negedge clk); lc[0] = 1'b0;
        chk("err_on_busy_load", 32'(er0), 1);
        wait_ov(0);
        send(0, 16'd200, 16'd150, 1'b0, 1'b0, 1'b0);

        // count_done on the 8th and 16th outputs only.
        do_reset();
        load(0, 64'h0000_0000_0000_4000);
        for (int i = 1; i <= 16; i++) begin
            send(0, 16'(i * 10), 16'(i * 5), 1'b0, (i == 8) || (i == 16), 1'b0);
        end

        // Reset in the second MAC cycle aborts the computation.
        do_reset();
        load(0, 64'h0000_0000_4000_4000);
        send(0, 16'd100, 16'd50, 1'b0, 1'b0, 1'b0);
        @(negedge clk); sd[0] = 16'd200; dr[0] = 1'b1;
        @(negedge clk); dr[0] = 1'b0;
        @(negedge clk); sd[0] = 16'd7;   dr[0] = 1'b1;
        @(negedge clk); dr[0] = 1'b0;
        chk("pre_abort_err", 32'(er0), 1);
        chk("pre_abort_fir_out", 32'(fo0), 50);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_zero_outputs("abort");
        repeat (10) @(negedge clk);
        send(0, 16'd300, 16'd0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("queue0_drained", 32'(q0.size()), 0);
        chk("queue1_drained", 32'(q1.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
